div_seq_ctrl: RTL and testbench
===============================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: clear  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request a division; sampled only in IDLE.
REQ-005 Port: signed_op  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-006 Port: dividend  input  WIDTH  numerator; sampled on the accepted-start edge.
REQ-007 Port: divisor  input  WIDTH  denominator; sampled on the accepted-start edge.
REQ-008 Port: busy  output  1  high from the cycle after accept until the DONE cycle, exclusive.
REQ-009 Port: done  output  1  one-cycle pulse; results valid.
REQ-010 Port: quotient  output  WIDTH  registered quotient (LO destination).
REQ-011 Port: remainder  output  WIDTH  registered remainder (HI destination).
REQ-012 Port: div_by_zero  output  1  registered; set with done when divisor == 0.

Function
REQ-013 States SHALL be IDLE, ITER, FIX, DONE.
REQ-014 IDLE with start=1 SHALL accept: latch sign flags, operand magnitudes (negate if signed_op and MSB=1), accumulator=0, counter=0.
REQ-015 Accept with divisor==0 SHALL go IDLE->DONE directly: quotient=all ones, remainder=dividend unchanged, div_by_zero=1.
REQ-016 Otherwise IDLE->ITER; one restoring step per cycle: shift {A,Q} left 1, A=A-M; if A negative restore A and Q[0]=0, else Q[0]=1.
REQ-017 Accumulator SHALL be WIDTH+1 bits, so no step overflows.
REQ-018 ITER SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), then go to FIX.
REQ-019 FIX SHALL negate the quotient when the operand signs differ (signed_op only), negate the remainder when the dividend was negative (signed_op only), and register both outputs.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Latency: accept on edge 0; done high in cycle WIDTH+2 (34 for WIDTH=32); divide-by-zero case done in cycle 1.
REQ-022 start while busy or in DONE SHALL be ignored; it is not queued.
REQ-023 quotient, remainder, div_by_zero SHALL hold their values until the next DONE; div_by_zero SHALL clear at the next accept.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, no flag.
REQ-025 Operand changes after accept SHALL not affect the result.

Reset
REQ-026 clear=1 SHALL force IDLE on the next edge from any state, aborting any operation in flight.
REQ-027 Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-028 clear SHALL take priority over start in the same cycle.

Structure
REQ-029 Package div_pkg SHALL hold the state enumeration, DIV_WIDTH=32 and the counter width (clog2 of WIDTH).
REQ-030 One combinational sub-module div_step SHALL implement a single restoring iteration (A,Q,M in; A',Q' out).
REQ-031 The controller SHALL contain no combinational loop across iterations; exactly one div_step instance.

Verification
REQ-032 Signed 100 / 7 -> quotient 14, remainder 2, done in cycle 34 only.
REQ-033 Signed -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100 / -7 -> 0xFFFFFFF2, 2.
REQ-034 Unsigned 0xFFFFFFFF / 2 -> quotient 0x7FFFFFFF, remainder 1; same operands signed -> quotient 0, remainder 0xFFFFFFFF.
REQ-035 Divisor 0, dividend 0x1234 -> done in cycle 1, quotient 0xFFFFFFFF, remainder 0x1234, div_by_zero=1.
REQ-036 start re-pulsed in cycle 5 -> ignored, done only in cycle 34; clear in cycle 10 -> IDLE, busy=0, outputs 0, no done.
REQ-037 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_by_zero=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract M,
// keep the difference if it did not go negative, and shift in the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);
  // One extra bit above the accumulator so the borrow of the trial
  // subtraction is a plain sign bit.
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  logic             neg;

  // Trial subtraction and restore decision
  always_comb begin
    sh     = {a, q[WIDTH-1]};
    diff   = sh - {2'b00, m};
    neg    = diff[WIDTH+1];
    a_next = neg ? sh[WIDTH:0] : diff[WIDTH:0];
    q_next = {q[WIDTH-2:0], ~neg};
  end
endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential signed/unsigned divider: one restoring step per cycle,
// followed by a sign-fix cycle and a one-cycle done pulse.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q_reg, m_reg;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] q_step;
  logic             dvd_neg, dvs_neg;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (acc),
    .q      (q_reg),
    .m      (m_reg),
    .a_next (acc_step),
    .q_next (q_step)
  );

  // State register; clear wins over everything
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : ITER;
      ITER: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clock) begin
    if (clear) begin
      acc         <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          neg_q       <= dvd_neg ^ dvs_neg;
          neg_r       <= dvd_neg;
          acc         <= '0;
          cnt         <= '0;
          q_reg       <= dvd_neg ? -dividend : dividend;
          m_reg       <= dvs_neg ? -divisor : divisor;
          div_by_zero <= 1'b0;
          // Zero divisor skips the iteration and reports immediately
          if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        ITER: begin
          acc   <= acc_step;
          q_reg <= q_step;
          cnt   <= cnt + CW'(1);
        end
        FIX: begin
          quotient  <= neg_q ? -q_reg : q_reg;
          remainder <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (WIDTH=32).
module tb_div_seq_ctrl;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear, start, signed_op;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference: plain 64-bit arithmetic, C-style truncating division
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic dz);
    longint x, y;
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else begin
      x  = s ? longint'({{32{a[W-1]}}, a}) : longint'({32'b0, a});
      y  = s ? longint'({{32{b[W-1]}}, b}) : longint'({32'b0, b});
      q  = 32'(x / y);
      r  = 32'(x % y);
      dz = 1'b0;
    end
  endfunction

  // Launch one division; returns the cycle done was seen (0 = never),
  // number of pre-done cycles with busy low, and the results at done.
  // Operand inputs are scrambled right after accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int pulse_cyc, output int done_cyc, output int busy_bad,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int cyc;
    @(negedge clock);
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = 1'($urandom);
    cyc = 1; done_cyc = 0; busy_bad = 0;
    while (done_cyc == 0 && cyc <= W + 10) begin
      if (done === 1'b1) done_cyc = cyc;
      else begin
        if (busy !== 1'b1) busy_bad++;
        if (cyc == pulse_cyc) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc++;
      end
    end
    q = quotient; r = remainder; dz = div_by_zero;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b dz=%b q=%h r=%h, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clock); clear = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         s;
    logic [W-1:0] q, r;
    logic         dz;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    int dc, bb;
    logic [W-1:0] q, r;
    logic dz;
    v[0] = '{32'd100,      32'd7,        1'b1, 32'd14,       32'd2,        1'b0};
    v[1] = '{-32'sd100,    32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    v[2] = '{32'd100,      -32'sd7,      1'b1, 32'hFFFFFFF2, 32'd2,        1'b0};
    v[3] = '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h7FFFFFFF, 32'd1,        1'b0};
    v[4] = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF, 1'b0};
    v[5] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0};
    v[6] = '{32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1};
    foreach (v[i]) begin
      run_op(v[i].a, v[i].b, v[i].s, 0, dc, bb, q, r, dz);
      checks++;
      if (dc != (v[i].dz ? 1 : W + 2)) begin
        errors++;
        $display("FAIL directed[%0d] latency: done cycle %0d, want %0d", i, dc, v[i].dz ? 1 : W + 2);
      end
      checks++;
      if (bb != 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] busy: low-before-done=%0d busy@done=%b, want 0/0", i, bb, busy);
      end
      checks++;
      if (q !== v[i].q || r !== v[i].r || dz !== v[i].dz) begin
        errors++;
        $display("FAIL directed[%0d] result: q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                 i, q, r, dz, v[i].q, v[i].r, v[i].dz);
      end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || quotient !== v[i].q || remainder !== v[i].r) begin
        errors++;
        $display("FAIL directed[%0d] pulse/hold: done=%b q=%h r=%h, want done=0 q=%h r=%h",
                 i, done, quotient, remainder, v[i].q, v[i].r);
      end
    end
  endtask

  task automatic test_random();
    int dc, bb;
    logic [W-1:0] a, b, q, r, eq, er;
    logic s, dz, edz;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      case ($urandom_range(3))
        0: b = '0;
        1: b = 32'($urandom_range(15));
        2: b = -32'($urandom_range(15));
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      ref_div(a, b, s, eq, er, edz);
      run_op(a, b, s, 0, dc, bb, q, r, dz);
      checks++;
      if (dc != (edz ? 1 : W + 2) || bb != 0 || q !== eq || r !== er || dz !== edz) begin
        errors++;
        $display("FAIL random %h/%h s=%b: cyc=%0d busylow=%0d q=%h r=%h dz=%b, want cyc=%0d q=%h r=%h dz=%b",
                 a, b, s, dc, bb, q, r, dz, edz ? 1 : W + 2, eq, er, edz);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_ignore_start();
    int dc, bb;
    logic [W-1:0] q, r;
    logic dz;
    run_op(32'd1000, 32'd9, 1'b0, 5, dc, bb, q, r, dz);
    checks++;
    if (dc != W + 2 || q !== 32'd111 || r !== 32'd1 || dz !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy: cyc=%0d q=%h r=%h dz=%b, want cyc=%0d q=6f r=1 dz=0",
               dc, q, r, dz, W + 2);
    end
    // start asserted during the DONE cycle must not launch anything
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd111) begin
      errors++;
      $display("FAIL ignore_done: busy=%b done=%b q=%h, want 0 0 6f", busy, done, quotient);
    end
  endtask

  task automatic test_clear_abort();
    int cyc, seen;
    @(negedge clock);
    dividend = 32'd1000; divisor = 32'd3; signed_op = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; cyc = 1;
    while (cyc < 10) begin @(posedge clock); #1; cyc++; end
    clear = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
      errors++;
      $display("FAIL clear_abort: busy=%b done=%b dz=%b q=%h r=%h, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clock); clear = 1'b0; start = 1'b0;
    seen = 0;
    repeat (W + 8) begin @(posedge clock); #1; if (done || busy) seen++; end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL clear_nodone: %0d cycles with busy/done after abort, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int dc, bb, cyc;
    logic [W-1:0] q, r;
    logic dz;
    run_op(32'h55, 32'd0, 1'b1, 0, dc, bb, q, r, dz);
    @(posedge clock); #1;
    @(negedge clock);
    dividend = 32'd77; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (div_by_zero !== 1'b0 || quotient !== 32'hFFFFFFFF || remainder !== 32'h55) begin
      errors++;
      $display("FAIL b2b_accept: dz=%b q=%h r=%h, want dz=0 q=ffffffff r=55", div_by_zero, quotient, remainder);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc <= W + 10) begin @(posedge clock); #1; cyc++; end
    checks++;
    if (cyc != W + 2 || quotient !== 32'd15 || remainder !== 32'd2) begin
      errors++;
      $display("FAIL b2b_result: cyc=%0d q=%h r=%h, want cyc=%0d q=f r=2", cyc, quotient, remainder, W + 2);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_clear_abort();
    test_ignore_start();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
